// File: rtl/ddr_app_pkg.sv
// Shared constants for the MIG 7-series user (app_*) interface models.
package ddr_app_pkg;

    localparam int APP_DATA_WIDTH_DEF = 128;
    localparam int APP_ADDR_WIDTH_DEF = 28;

    // app_addr counts DQ words; one 128-bit beat covers eight of them
    localparam int BEAT_ADDR_SHIFT = 3;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mig_app_responder.sv
// On-chip stand-in for mig_7series_0: app_* command/data FIFOs, beat RAM and fixed-latency reads.
// Define MIG_RESP_STALL_EN to add LFSR-driven random deassertion of app_rdy / app_wdf_rdy.
module mig_app_responder
    import ddr_app_pkg::*;
#(
    parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DEF,
    parameter int APP_ADDR_WIDTH = APP_ADDR_WIDTH_DEF,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int RD_LATENCY     = 6,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        init_calib_complete,
    input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]                  app_cmd,
    input  logic                        app_en,
    output logic                        app_rdy,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    output logic                        app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        app_rd_data_end
);

    localparam int MASK_W    = APP_DATA_WIDTH / 8;
    localparam int CMD_W     = 3 + APP_ADDR_WIDTH;
    localparam int WDF_W     = APP_DATA_WIDTH + MASK_W;
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
    localparam int FCNT_W    = $clog2(CMD_FIFO_DEPTH) + 1;

    logic [CAL_W-1:0]          cal_cnt;
    logic                      cmd_stall;
    logic                      wdf_stall;

    logic                      cmd_push;
    logic                      cmd_pop;
    logic [CMD_W-1:0]          cmd_head;
    logic                      cmd_full;
    logic                      cmd_empty;
    logic [FCNT_W-1:0]         cmd_count;

    logic                      wdf_push;
    logic                      wdf_pop;
    logic [WDF_W-1:0]          wdf_head;
    logic                      wdf_full;
    logic                      wdf_empty;
    logic [FCNT_W-1:0]         wdf_count;

    logic [2:0]                head_cmd;
    logic [APP_ADDR_WIDTH-1:0] head_addr;
    logic [MEM_DEPTH_LOG2-1:0] head_idx;
    logic [APP_DATA_WIDTH-1:0] head_data;
    logic [MASK_W-1:0]         head_mask;
    logic                      exec_read;
    logic                      exec_write;

    logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [RD_LATENCY-1:0]     rd_valid_pipe;
    logic [APP_DATA_WIDTH-1:0] rd_data_pipe [RD_LATENCY];

    logic                      unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cal_cnt             <= '0;
            init_calib_complete <= 1'b0;
        end else if (!init_calib_complete) begin
            cal_cnt <= cal_cnt + CAL_W'(1);
            if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                init_calib_complete <= 1'b1;
            end
        end
    end

`ifdef MIG_RESP_STALL_EN
    logic [15:0] lfsr;

    // Taps 16/14/13/11 in right-shift form
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign cmd_stall = (lfsr[1:0] == 2'b00);
    assign wdf_stall = (lfsr[3:2] == 2'b00);
`else
    assign cmd_stall = 1'b0;
    assign wdf_stall = 1'b0;
`endif

    assign app_rdy     = init_calib_complete && !cmd_full && !cmd_stall;
    assign app_wdf_rdy = init_calib_complete && !wdf_full && !wdf_stall;
    assign cmd_push    = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .din   ({app_cmd, app_addr}),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    sync_fifo #(
        .WIDTH (WDF_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_wdf_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wdf_push),
        .pop   (wdf_pop),
        .din   ({app_wdf_data, app_wdf_mask}),
        .dout  (wdf_head),
        .full  (wdf_full),
        .empty (wdf_empty),
        .count (wdf_count)
    );

    assign head_cmd  = cmd_head[CMD_W-1 -: 3];
    assign head_addr = cmd_head[APP_ADDR_WIDTH-1:0];
    assign head_idx  = head_addr[MEM_DEPTH_LOG2+BEAT_ADDR_SHIFT-1 : BEAT_ADDR_SHIFT];
    assign head_data = wdf_head[WDF_W-1 -: APP_DATA_WIDTH];
    assign head_mask = wdf_head[MASK_W-1:0];

    // A write at the head waits for its data beat, holding back later reads
    always_comb begin
        exec_read  = 1'b0;
        exec_write = 1'b0;
        cmd_pop    = 1'b0;
        wdf_pop    = 1'b0;
        if (!cmd_empty) begin
            case (head_cmd)
                APP_CMD_READ: begin
                    exec_read = 1'b1;
                    cmd_pop   = 1'b1;
                end
                APP_CMD_WRITE: begin
                    if (!wdf_empty) begin
                        exec_write = 1'b1;
                        cmd_pop    = 1'b1;
                        wdf_pop    = 1'b1;
                    end
                end
                default: cmd_pop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (exec_write) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!head_mask[b]) begin
                    mem[head_idx][8*b +: 8] <= head_data[8*b +: 8];
                end
            end
        end
    end

    // Only one command executes per cycle, so a write has committed at the
    // edge before any following read samples the array: read-after-write
    // to the same beat returns the new data without a separate bypass mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                rd_data_pipe[i] <= '0;
            end
        end else begin
            rd_valid_pipe[0] <= exec_read;
            if (exec_read) begin
                rd_data_pipe[0] <= mem[head_idx];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_valid_pipe[i] <= rd_valid_pipe[i-1];
                rd_data_pipe[i]  <= rd_data_pipe[i-1];
            end
        end
    end

    assign app_rd_data       = rd_data_pipe[RD_LATENCY-1];
    assign app_rd_data_valid = rd_valid_pipe[RD_LATENCY-1];
    assign app_rd_data_end   = rd_valid_pipe[RD_LATENCY-1];

    assign unused_bits = ^{head_addr, app_wdf_end, cmd_count, wdf_count};

endmodule

// File: tb/tb_mig_app_responder.sv
// Scoreboard bench for mig_app_responder: directed app_* traffic, monitor checks every read beat.
module tb_mig_app_responder;
    import ddr_app_pkg::*;

    localparam int RD_LAT = 6;

    localparam logic [127:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DATA_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] DATA_C = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
    localparam logic [127:0] ONES   = {128{1'b1}};
    localparam logic [127:0] MASKED = {{15{8'hFF}}, 8'h00};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;

    int     assertions = 0;
    int     failures   = 0;
    int     valid_count = 0;
    longint cycle = 0;

    typedef struct {
        logic [127:0] data;
        bit           check_lat;
        longint       due;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    mig_app_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // Monitor: every read beat is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && app_rd_data_valid) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                checkOutput("rd_valid_not_expected", 128'(app_rd_data_valid), 128'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rd_data", app_rd_data, e.data);
                checkOutput("rd_data_end", 128'(app_rd_data_end), 128'd1);
                if (e.check_lat) begin
                    checkOutput("rd_latency_cycle", 128'(cycle), 128'(e.due));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] cmd, input logic [27:0] addr, output longint acc_cycle);
        int waited = 0;
        app_cmd  = cmd;
        app_addr = addr;
        app_en   = 1'b1;
        @(negedge clk);
        while (!app_rdy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!app_rdy) begin
            checkOutput("cmd_accept_timeout", 128'(app_rdy), 128'd1);
        end
        acc_cycle = cycle;
        @(posedge clk);
        #1;
        app_en = 1'b0;
    endtask

    task automatic applyWriteData(input logic [127:0] data, input logic [15:0] mask);
        int waited = 0;
        app_wdf_data = data;
        app_wdf_mask = mask;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        @(negedge clk);
        while (!app_wdf_rdy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!app_wdf_rdy) begin
            checkOutput("wdf_accept_timeout", 128'(app_wdf_rdy), 128'd1);
        end
        @(posedge clk);
        #1;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic issueWrite(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        longint acc;
        applyStimulus(APP_CMD_WRITE, addr, acc);
        applyWriteData(data, mask);
    endtask

    // Read accepted in cycle a executes in a+1; the beat follows RD_LAT cycles later
    task automatic issueRead(input logic [27:0] addr, input logic [127:0] data, input bit check_lat);
        longint acc;
        exp_t   e;
        applyStimulus(APP_CMD_READ, addr, acc);
        e.data      = data;
        e.check_lat = check_lat;
        e.due       = acc + 1 + RD_LAT;
        exp_q.push_back(e);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint acc;
        int     snapshot;
        int     waited;

        app_addr     = '0;
        app_cmd      = '0;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_mask = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;

        $display("[TB] reset and calibration");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_calib", 128'(init_calib_complete), 128'd0);
        checkOutput("rst_app_rdy", 128'(app_rdy), 128'd0);
        checkOutput("rst_wdf_rdy", 128'(app_wdf_rdy), 128'd0);
        checkOutput("rst_rd_valid", 128'(app_rd_data_valid), 128'd0);
        checkOutput("rst_rd_data", app_rd_data, 128'd0);
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("calib_cycle_%0d", k), 128'(init_calib_complete), 128'(k >= 64));
            if (k == 63 || k == 64) begin
                checkOutput($sformatf("app_rdy_cycle_%0d", k), 128'(app_rdy), 128'(k >= 64));
                checkOutput($sformatf("wdf_rdy_cycle_%0d", k), 128'(app_wdf_rdy), 128'(k >= 64));
            end
        end

        $display("[TB] basic write then read with latency check");
        issueWrite(28'h0000010, DATA_A, 16'h0000);
        issueRead(28'h0000010, DATA_A, 1'b1);
        waitDrain("drain_basic");

        $display("[TB] byte mask merge");
        issueWrite(28'h0000008, ONES, 16'h0000);
        issueWrite(28'h0000008, 128'd0, 16'hFFFE);
        issueRead(28'h0000008, MASKED, 1'b0);
        waitDrain("drain_mask");

        $display("[TB] write command stalled on missing data");
        applyStimulus(APP_CMD_WRITE, 28'h0000018, acc);
        issueRead(28'h0000018, DATA_B, 1'b0);
        issueRead(28'h0000010, DATA_A, 1'b0);
        issueRead(28'h0000008, MASKED, 1'b0);
        @(negedge clk);
        checkOutput("app_rdy_cmd_fifo_full", 128'(app_rdy), 128'd0);
        snapshot = valid_count;
        repeat (20) @(negedge clk);
        checkOutput("no_valid_while_stalled", 128'(valid_count), 128'(snapshot));
        @(posedge clk);
        #1;
        applyWriteData(DATA_B, 16'h0000);
        waitDrain("drain_stall");

        $display("[TB] address aliasing beyond RAM depth");
        issueWrite(28'h0002000, DATA_C, 16'h0000);
        issueRead(28'h0000000, DATA_C, 1'b0);
        waitDrain("drain_alias");

        $display("[TB] reset with reads in flight");
        applyStimulus(APP_CMD_READ, 28'h0000010, acc);
        applyStimulus(APP_CMD_READ, 28'h0000010, acc);
        applyStimulus(APP_CMD_READ, 28'h0000010, acc);
        rst = 1'b1;
        snapshot = valid_count;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("calib_low_after_rst", 128'(init_calib_complete), 128'd0);
        checkOutput("app_rdy_low_after_rst", 128'(app_rdy), 128'd0);
        waited = 0;
        while (!init_calib_complete && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("recalib_done", 128'(init_calib_complete), 128'd1);
        repeat (10) @(negedge clk);
        checkOutput("no_valid_after_rst", 128'(valid_count), 128'(snapshot));
        @(posedge clk);
        #1;
        issueRead(28'h0000010, DATA_A, 1'b1);
        waitDrain("drain_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
- Synthesizable responder for the MIG 7-series user (app_*) interface.
- Stands in for mig_7series_0 so ddr_controller can be exercised in simulation and on boards without DDR3.
- Accepts read/write commands and write data, stores 128-bit beats in on-chip RAM, and returns read data in order after a fixed latency.
- Drives ui_clk-domain signals only; no DDR3 pins.

Parameters:
- APP_DATA_WIDTH, 128, width of app_wdf_data / app_rd_data.
- APP_ADDR_WIDTH, 28, width of app_addr.
- MEM_DEPTH_LOG2, 10, log2 of the number of 128-bit beats stored.
- CMD_FIFO_DEPTH, 4, depth of the command queue and of the write-data queue (power of 2).
- RD_LATENCY, 6, cycles from read execution to app_rd_data_valid (minimum 1).
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.

Ports:
- clk  in  1  ui_clk-domain clock.
- rst  in  1  asynchronous, active-high reset.
- init_calib_complete  out  1  high once calibration delay has elapsed.
- app_addr  in  APP_ADDR_WIDTH  command address, DQ-word units.
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_rdy  out  1  command accepted when app_en && app_rdy.
- app_wdf_data  in  APP_DATA_WIDTH  write beat.
- app_wdf_mask  in  APP_DATA_WIDTH/8  1 = byte not written.
- app_wdf_wren  in  1  write-data valid.
- app_wdf_end  in  1  last beat; always high with wren in 4:1 BL8.
- app_wdf_rdy  out  1  write data accepted when app_wdf_wren && app_wdf_rdy.
- app_rd_data  out  APP_DATA_WIDTH  read beat.
- app_rd_data_valid  out  1  read beat valid, one cycle per beat.
- app_rd_data_end  out  1  equals app_rd_data_valid.

Behaviour:
- Reset: all outputs 0; FIFOs, read pipeline and calibration counter cleared. RAM contents are not reset and are retained across rst.
- Calibration:
  - Counter runs from 0 after rst deasserts.
  - init_calib_complete rises at cycle CALIB_CYCLES and stays high until the next rst.
- Ready signals:
  - app_rdy = init_calib_complete && cmd FIFO not full.
  - app_wdf_rdy = init_calib_complete && wdf FIFO not full.
  - Both are registered-state derived, never a function of app_en or app_wdf_wren.
- Command path:
  - An accepted command pushes {cmd, addr} into the cmd FIFO.
  - Accepted write data pushes {data, mask} into the wdf FIFO.
  - Data may arrive before, with, or after its command.
- Executor: in-order, at most one command per cycle, taken from the cmd FIFO head.
  - READ: pops immediately. Issues RAM read of index app_addr[MEM_DEPTH_LOG2+2:3]; the low 3 bits are ignored and upper bits wrap.
  - WRITE: pops only when the wdf FIFO is non-empty. Pops both FIFOs and writes the unmasked bytes. A WRITE at head with empty wdf stalls the executor, blocking subsequent reads (preserves read-after-write order).
  - Other cmd codes: popped, no effect, no read data.
- Read return:
  - app_rd_data_valid asserts exactly RD_LATENCY cycles after the READ pops.
  - Delivered through a RD_LATENCY-stage valid/data pipeline; back-to-back reads give back-to-back valids.
  - No backpressure.
- Hazards: a READ executed the cycle after a WRITE to the same index returns the new data (RAM read-after-write bypass required).
- Full boundaries:
  - Cmd FIFO full → app_rdy=0.
  - Push and pop in the same cycle on a full FIFO is not permitted; app_rdy is already low.
  - Simultaneous push and pop on a non-full FIFO keeps the count.
- Mid-operation rst: in-flight reads are dropped (no valid) and queued writes are discarded. After release, calibration restarts.

Optional Feature:
- MIG_RESP_STALL_EN defined:
  - A 16-bit LFSR (seed 16'hACE1 on reset, polynomial x^16+x^14+x^13+x^11+1) advances every cycle.
  - app_rdy is additionally forced low when lfsr[1:0]==2'b00.
  - app_wdf_rdy is additionally forced low when lfsr[3:2]==2'b00.
  - Purpose: stress initiator handshakes.
- Undefined: no LFSR; ready signals exactly as above.

Decomposition:
- Package ddr_app_pkg:
  - APP_CMD_WRITE=3'b000 and APP_CMD_READ=3'b001.
  - Beat-to-address shift (3).
  - Shared default widths (128, 28).
- Sub-module sync_fifo (parameterized width/depth; push, pop, full, empty, count), instantiated twice: cmd FIFO and wdf FIFO.

Test Plan:
- Reset then idle → init_calib_complete=0 through cycle 63, =1 at cycle 64. app_rdy/app_wdf_rdy=0 before, =1 after.
- Write addr 28'h0000010, data 128'h0123…CDEF, mask 0; then read addr 28'h0000010 → app_rd_data_valid exactly 6 cycles after the read pops, data 128'h0123…CDEF, app_rd_data_end=1.
- Write all-ones to addr 0x08, then write 128'h0 with mask 16'hFFFE → read returns 128'hFF…FF00.
- Issue write command with no data, then 3 reads → app_rdy drops after the FIFO fills (4 entries); no read valid until wdf beat supplied; reads then return in order.
- Address 28'h0002000 (beyond depth 1024 beats) aliases beat 0: write there, read addr 0 → same data.
- Assert rst for 1 cycle while 3 reads in flight → no app_rd_data_valid afterwards; RAM data preserved on re-read after recalibration.
